// File: rtl/servo_slew_limiter.sv
// servo_slew_limiter: clamps a pulse-width target and slews angle_out toward it
// by at most one step per frame. Optional ramped step: SERVO_SLEW_ACCEL_EN.
// Ports: clk, reset (async, active-low), en, target[WIDTH] -> angle_out, settled, frame_tick
module servo_slew_limiter #(
  parameter int WIDTH        = 24,
  parameter int FRAME_CYCLES = 2000000,
  parameter int STEP         = 2000,
  parameter int MIN_PULSE    = 100000,
  parameter int MAX_PULSE    = 200000,
  parameter int HOME_PULSE   = 150000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] angle_out,
  output logic             settled,
  output logic             frame_tick
);

  typedef enum logic {HOLD, MOVE} state_t;

  localparam int CW =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(FRAME_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] HOME_W = WIDTH'(HOME_PULSE);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic                bnd;
  logic [WIDTH-1:0]    tclamp;
  logic [WIDTH-1:0]    tlat;
  logic [WIDTH-1:0]    a_nxt;
  logic [WIDTH-1:0]    t_nxt;
  logic [WIDTH-1:0]    step_use;
  logic signed [WIDTH:0] d;
  logic [WIDTH:0]      mag;

  assign tclamp = (target < MIN_W) ? MIN_W :
                  (target > MAX_W) ? MAX_W : target;

  assign bnd = en && (cnt == LAST);

  // One extra bit so the difference never wraps.
  assign d = $signed({1'b0, tclamp})
           - $signed({1'b0, angle_out});
  assign mag = d[WIDTH] ? $unsigned(-d) : $unsigned(d);

`ifdef SERVO_SLEW_ACCEL_EN
  localparam int QI = (STEP / 4 < 1) ? 1 : STEP / 4;
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(QI);

  logic [WIDTH-1:0] stp, stp_nxt;
  logic             dir_q, dir_nxt;

  // A reversal while moving restarts the ramp.
  assign step_use =
    (state == MOVE && d[WIDTH] != dir_q) ? Q_W : stp;
`else
  assign step_use = STEP_W;
`endif

  always_comb begin
    state_nxt = state;
    a_nxt     = angle_out;
    t_nxt     = tlat;
`ifdef SERVO_SLEW_ACCEL_EN
    stp_nxt   = stp;
    dir_nxt   = dir_q;
`endif
    unique case (1'b1)
      !en: begin
        state_nxt = HOLD;
`ifdef SERVO_SLEW_ACCEL_EN
        stp_nxt   = Q_W;
`endif
      end
      bnd: begin
        t_nxt = tclamp;
        if (mag <= {1'b0, step_use}) begin
          a_nxt     = tclamp;
          state_nxt = HOLD;
`ifdef SERVO_SLEW_ACCEL_EN
          stp_nxt   = Q_W;
`endif
        end else begin
          state_nxt = MOVE;
          a_nxt = d[WIDTH] ? angle_out - step_use
                           : angle_out + step_use;
`ifdef SERVO_SLEW_ACCEL_EN
          dir_nxt = d[WIDTH];
          stp_nxt = (step_use >= STEP_W - Q_W)
                  ? STEP_W : step_use + Q_W;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HOLD;
      cnt        <= '0;
      angle_out  <= HOME_W;
      tlat       <= HOME_W;
      settled    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= (!en || cnt == LAST)
                  ? '0 : cnt + CW'(1);
      angle_out  <= a_nxt;
      tlat       <= t_nxt;
      settled    <= (a_nxt == t_nxt);
      frame_tick <= bnd;
    end
  end

`ifdef SERVO_SLEW_ACCEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stp   <= Q_W;
      dir_q <= 1'b0;
    end else begin
      stp   <= stp_nxt;
      dir_q <= dir_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_servo_slew_limiter.sv
// tb_servo_slew_limiter: directed bench with a per-cycle reference model
// for servo_slew_limiter (small frame/step parameters).
module tb_servo_slew_limiter;

  localparam int W    = 24;
  localparam int FC   = 10;
  localparam int ST   = 100;
  localparam int MINP = 1000;
  localparam int MAXP = 2000;
  localparam int HOME = 1500;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] target;
  logic [W-1:0] angle_out;
  logic         settled;
  logic         frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int ticks  = 0;

  servo_slew_limiter #(
    .WIDTH(W), .FRAME_CYCLES(FC), .STEP(ST),
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
    .HOME_PULSE(HOME)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .target(target), .angle_out(angle_out),
    .settled(settled), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (frame_tick) ticks <= ticks + 1;
  end

  task automatic check(input string nm,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clampf(input int t);
    return (t < MINP) ? MINP : (t > MAXP) ? MAXP : t;
  endfunction

  function automatic int absf(input int v);
    return (v < 0) ? -v : v;
  endfunction

  int m_angle, m_tlat, m_cnt, m_step;
  bit m_tick, m_settled, m_move, m_down;

  function automatic int cur_step(input int dd);
`ifdef SERVO_SLEW_ACCEL_EN
    if (m_move && ((dd < 0) != m_down)) return ST / 4;
    return m_step;
`else
    return ST + 0 * dd;
`endif
  endfunction

  function automatic int next_angle(input int a,
                                    input int t,
                                    input int s);
    if (absf(t - a) <= s) return t;
    return (t > a) ? a + s : a - s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_angle   <= HOME;
      m_tlat    <= HOME;
      m_cnt     <= 0;
      m_tick    <= 1'b0;
      m_settled <= 1'b1;
      m_move    <= 1'b0;
      m_down    <= 1'b0;
      m_step    <= ST / 4;
    end else begin
      m_cnt  <= (!en || m_cnt == FC - 1) ? 0 : m_cnt + 1;
      m_tick <= en && (m_cnt == FC - 1);
      if (!en) begin
        m_move <= 1'b0;
        m_step <= ST / 4;
        m_settled <= (m_angle == m_tlat);
      end else if (m_cnt == FC - 1) begin
        m_tlat  <= clampf(int'(target));
        m_angle <= next_angle(m_angle,
                     clampf(int'(target)),
                     cur_step(clampf(int'(target)) - m_angle));
        m_settled <= 1'b0;
        if (absf(clampf(int'(target)) - m_angle)
            <= cur_step(clampf(int'(target)) - m_angle)) begin
          m_settled <= 1'b1;
          m_move    <= 1'b0;
          m_step    <= ST / 4;
        end else begin
          m_move <= 1'b1;
          m_down <= (clampf(int'(target)) < m_angle);
          m_step <= (cur_step(clampf(int'(target)) - m_angle)
                     + ST / 4 > ST) ? ST :
                    cur_step(clampf(int'(target)) - m_angle)
                     + ST / 4;
        end
      end else begin
        m_settled <= (m_angle == m_tlat);
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("angle_model", int'(angle_out), m_angle);
      check("settled_model", int'(settled), int'(m_settled));
      check("tick_model", int'(frame_tick), int'(m_tick));
      check("angle_range",
            int'(angle_out >= MINP && angle_out <= MAXP), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_tick && n < 4 * FC);
    check("tick_timeout", int'(frame_tick), 1);
  endtask

  int t1;
  int tk0;

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    target = W'(HOME);
    cyc(2);
    check("rst_angle", int'(angle_out), 1500);
    check("rst_settled", int'(settled), 1);
    check("rst_tick", int'(frame_tick), 0);
    reset = 1'b1;
    en    = 1'b1;

    // frame period
    wait_tick();
    t1 = cyc_n;
    wait_tick();
    check("tick_period", cyc_n - t1, FC);
    check("home_hold", int'(angle_out), 1500);

`ifdef SERVO_SLEW_ACCEL_EN
    target = W'(2000);
    wait_tick(); check("acc_1", int'(angle_out), 1525);
    wait_tick(); check("acc_2", int'(angle_out), 1575);
    wait_tick(); check("acc_3", int'(angle_out), 1650);
    wait_tick(); check("acc_4", int'(angle_out), 1750);
    wait_tick(); check("acc_5", int'(angle_out), 1850);
    wait_tick(); check("acc_6", int'(angle_out), 1950);
    wait_tick(); check("acc_7", int'(angle_out), 2000);
    check("acc_settled", int'(settled), 1);
`else
    // slew up
    target = W'(1750);
    wait_tick(); check("up_1", int'(angle_out), 1600);
    check("up_1_settled", int'(settled), 0);
    wait_tick(); check("up_2", int'(angle_out), 1700);
    wait_tick(); check("up_3", int'(angle_out), 1750);
    check("up_settled", int'(settled), 1);
    wait_tick(); check("up_hold", int'(angle_out), 1750);

    // clamp high then low
    target = W'(50000);
    repeat (3) wait_tick();
    check("clamp_hi", int'(angle_out), 2000);
    wait_tick();
    check("clamp_hi_hold", int'(angle_out), 2000);
    target = W'(0);
    repeat (9) wait_tick();
    check("down_9", int'(angle_out), 1100);
    wait_tick();
    check("clamp_lo", int'(angle_out), 1000);
    wait_tick();
    check("clamp_lo_hold", int'(angle_out), 1000);

    // enable gating
    target = W'(1500);
    repeat (5) wait_tick();
    check("back_1500", int'(angle_out), 1500);
    target = W'(1900);
    wait_tick();
    check("gate_start", int'(angle_out), 1600);
    cyc(3);
    en  = 1'b0;
    tk0 = ticks;
    cyc(50);
    check("gate_no_tick", ticks - tk0, 0);
    check("gate_frozen", int'(angle_out), 1600);
    en = 1'b1;
    cyc(9);
    check("gate_pre", int'(angle_out), 1600);
    cyc(1);
    check("gate_resume", int'(angle_out), 1700);
    check("gate_tick", int'(frame_tick), 1);

    // mid-frame target changes
    cyc(2); target = W'(1200);
    cyc(2); target = W'(1950);
    cyc(2); target = W'(1400);
    wait_tick();
    check("midframe", int'(angle_out), 1600);

    // async reset mid-move
    cyc(3);
    #3 reset = 1'b0;
    #1;
    check("async_angle", int'(angle_out), 1500);
    check("async_settled", int'(settled), 1);
    check("async_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    wait_tick();
    check("post_rst", int'(angle_out), 1400);
    check("post_rst_settled", int'(settled), 1);
`endif

    cyc(3);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_slew_limiter.md
Name: servo_slew_limiter

Overview:
Rate-limits a servo pulse-width command so the joint moves at a bounded speed. It sits between the inverse-kinematics stage and a servo pwm generator, with one instance per joint (shoulder, elbow). It clamps the raw target to the safe pulse range. Once per servo frame it moves its output toward the target by at most a fixed step, so keyboard jumps in x/y never slam the arm.

Parameters:
WIDTH, 24, pulse-width word width in clk cycles; matches the pwm compare width
FRAME_CYCLES, 2000000, clk cycles per update frame (20 ms at 100 MHz)
STEP, 2000, max change of angle_out per frame, in clk cycles
MIN_PULSE, 100000, lower clamp for target (1.0 ms)
MAX_PULSE, 200000, upper clamp for target (2.0 ms)
HOME_PULSE, 150000, angle_out value after reset (1.5 ms, centred)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; low forces all state to reset values immediately
en  input  1  motion enable; from the pwm enable stage
target  input  WIDTH  raw pulse-width command from inverse kinematics
angle_out  output  WIDTH  rate-limited pulse width to the pwm stage
settled  output  1  high when angle_out equals the clamped latched target
frame_tick  output  1  one-cycle pulse on the cycle angle_out may update

Behaviour:
- Reset (reset==0, async):
  - angle_out=HOME_PULSE, latched target=HOME_PULSE, frame counter=0, settled=1, frame_tick=0, state=HOLD.
- Clamp (combinational on target): tclamp = MIN_PULSE if target<MIN_PULSE; MAX_PULSE if target>MAX_PULSE; else target.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps to 0 while en=1.
  - While en=0: forced to 0, no frame_tick.
  - frame_tick is registered; high for exactly the one cycle after the counter holds FRAME_CYCLES-1.
- Target latch:
  - tclamp is sampled into tlat only on the edge where the counter equals FRAME_CYCLES-1.
  - Changes to target mid-frame are ignored until the next boundary.
- States:
  - HOLD: angle_out constant. Exits to MOVE on the frame boundary where en=1 and tclamp != angle_out.
  - MOVE: on each frame boundary (same edge as the latch), compute d = tlat_new - angle_out as a signed WIDTH+1-bit value.
    - If |d| <= STEP: angle_out <= tlat_new and go to HOLD.
    - Otherwise: angle_out <= angle_out ± STEP (sign of d) and stay in MOVE.
  - Any state, en=0: go to HOLD at the next edge; angle_out frozen at its current value (not homed).
- Latency:
  - A new target is first reflected in angle_out at most FRAME_CYCLES cycles after it is applied.
  - A full swing of N cycles takes ceil(N/STEP) frames.
- Arithmetic:
  - Use unsigned compare for the clamp.
  - The difference is one bit wider than WIDTH, so there is no wrap.
  - angle_out never leaves [min(HOME_PULSE, MIN_PULSE), max(HOME_PULSE, MAX_PULSE)].
- settled:
  - Registered; equals (angle_out == tlat).
  - Drops on the frame boundary that latches a differing target.
- Simultaneous events:
  - If en falls on a boundary edge, en=0 wins: no update, no latch.
  - A target change on the boundary edge is taken (sampled that edge).
- Reset mid-move: async return to the HOME_PULSE reset state; no partial step is retained.

Optional Feature:
SERVO_SLEW_ACCEL_EN
- Defined:
  - The per-frame step ramps instead of being constant.
  - A step register starts at STEP/4 (min 1) on entering MOVE and grows by STEP/4 each frame, saturating at STEP.
  - The step register resets to STEP/4 when d changes sign or on entering HOLD.
  - The snap rule (|d| <= current step) is unchanged.
- Not defined: constant STEP as described above; no step register exists.

Test Plan:
1. Reset/clamp: bench params FRAME_CYCLES=10, STEP=100, MIN=1000, MAX=2000, HOME=1500. Assert reset=0 then release with target=1500 -> angle_out=1500, settled=1, frame_tick pulses every 10 cycles.
2. Slew up: target=1750 with en=1 -> angle_out reads 1600, 1700, 1750 on successive frame_ticks, then HOLD with settled=1. Exactly 3 frames.
3. Clamp and direction: target=50000 -> angle_out rises 100 per frame and stops at 2000. Then target=0 -> angle_out falls to 1000 in 10 frames and never goes below it.
4. Enable gating: mid-move (angle_out=1600, target=1900), drop en for 50 cycles -> no frame_tick, angle_out stays 1600. Raise en -> 1700 after 10 cycles.
5. Mid-frame and reset: change target 3 times within one frame -> only the value present at the boundary is used. Assert reset=0 mid-MOVE -> angle_out=1500 immediately (async).
6. SERVO_SLEW_ACCEL_EN defined, 1500 -> 2000 -> step sequence 25, 50, 75, 100, 100, 100, 50 (snap): angle_out = 1525, 1575, 1650, 1750, 1850, 1950, 2000.
